// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
//
// EX-stage iterative multiply/divide unit that owns the HI/LO registers.
// Executes MULTU/MULT/DIVU/DIV from the ID/EX operands and raises stall_o
// while a dependent HI/LO access (or a new mul/div) waits for the result.
// All state changes happen on the falling edge of clk_i, like the pipeline
// registers around it.
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   defined   : MULT/MULTU load the full product with a single '*' at the
//               start edge; one RUN cycle, then FIX (2 cycles busy).
//   undefined : multiply is shift-add, one bit per cycle (WIDTH+1 cycles).
//   Divide is restoring, one quotient bit per cycle, in both builds.
//
// Ports
//   clk_i      in   1      pipeline clock, state updates on negedge
//   rst_n_i    in   1      asynchronous active-low reset
//   start_i    in   1      MULT/MULTU/DIV/DIVU present in EX
//   op_i       in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   data1_i    in   WIDTH  rs operand (multiplicand / dividend / MTHI,MTLO data)
//   data2_i    in   WIDTH  rt operand (multiplier / divisor)
//   hilo_rd_i  in   1      MFHI/MFLO present in EX
//   hi_we_i    in   1      MTHI present in EX
//   lo_we_i    in   1      MTLO present in EX
//   flush_i    in   1      EX flush, aborts the operation in flight
//   busy_o     out  1      operation in flight (state != IDLE)
//   stall_o    out  1      busy_o & (start_i | hilo_rd_i | hi_we_i | lo_we_i)
//   done_o     out  1      one-cycle pulse after the edge HI/LO take a result
//   hi_o       out  WIDTH  HI register
//   lo_o       out  WIDTH  LO register
//   state_o    out  2      FSM state for debug (0 IDLE, 1 RUN, 2 FIX)
//
// Handshake: there is no valid/ready pair. An instruction in EX is accepted
// only on an edge where stall_o is low; while stall_o is high the pipeline
// holds it in ID/EX and it re-presents every cycle until the unit is idle.
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             hilo_rd_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [1:0]       state_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div_q;   // operation in flight is a divide
    logic             div0_q;     // divide by zero: raw result, no sign fix
    logic             neg_lo_q;   // negate product / quotient at FIX
    logic             neg_hi_q;   // negate remainder at FIX
    logic [WIDTH-1:0] opnd_q;     // |multiplicand| or |divisor|
    logic [WIDTH-1:0] acc_hi_q;   // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo_q;   // multiplier bits / dividend -> quotient

    // ---------------------------------------------------------------------
    // Operand decode at the start edge
    // ---------------------------------------------------------------------
    logic             op_signed;
    logic             op_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign op_signed = op_i[0];
    assign op_div    = op_i[1];
    assign a_neg     = op_signed & data1_i[WIDTH-1];
    assign b_neg     = op_signed & data2_i[WIDTH-1];
    // The most negative value maps to itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    assign mag_a     = a_neg ? -data1_i : data1_i;
    assign mag_b     = b_neg ? -data2_i : data2_i;

    // ---------------------------------------------------------------------
    // Iteration datapath
    // ---------------------------------------------------------------------
`ifndef MULDIV_FAST_MUL_EN
    // Shift-add: {acc_hi, acc_lo} shifts right one bit per cycle; the LSB
    // of acc_lo is the current multiplier bit and the product grows into
    // the top. The extra sum bit is the carry shifted into acc_hi[WIDTH-1].
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
`else
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

    // Restoring divide: shift the next dividend bit into the remainder and
    // try to subtract. The remainder is always below the divisor, so the
    // shifted value fits WIDTH+1 bits and the top bit of the difference is
    // set exactly when the subtraction underflows.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;

    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};
    assign div_ge    = ~div_trial[WIDTH];

    // ---------------------------------------------------------------------
    // Sign correction applied at FIX
    // ---------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_fix = neg_lo_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    assign quo_fix  = neg_lo_q ? -acc_lo_q : acc_lo_q;
    assign rem_fix  = neg_hi_q ? -acc_hi_q : acc_hi_q;

    // ---------------------------------------------------------------------
    // FSM and HI/LO
    // ---------------------------------------------------------------------
    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= S_IDLE;
            count    <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            done_o   <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (flush_i) begin
                        // The EX instruction is squashed: neither a start nor
                        // an MTHI/MTLO may take effect.
                    end else if (start_i) begin
                        count    <= '0;
                        is_div_q <= op_div;
                        div0_q   <= 1'b0;
                        neg_lo_q <= a_neg ^ b_neg;
                        state    <= S_RUN;
                        if (op_div) begin
                            neg_hi_q <= a_neg;
                            opnd_q   <= mag_b;
                            acc_hi_q <= '0;
                            acc_lo_q <= mag_a;
                            if (data2_i == '0) begin
                                // Skip the iterations; FIX copies these raw.
                                div0_q   <= 1'b1;
                                acc_hi_q <= data1_i;
                                acc_lo_q <= '1;
                                state    <= S_FIX;
                            end
                        end else begin
                            neg_hi_q <= 1'b0;
                            opnd_q   <= mag_a;
`ifdef MULDIV_FAST_MUL_EN
                            {acc_hi_q, acc_lo_q} <= fast_prod;
                            count                <= CW'(WIDTH - 1);
`else
                            acc_hi_q <= '0;
                            acc_lo_q <= mag_b;
`endif
                        end
                    end else begin
                        if (hi_we_i) hi_o <= data1_i;
                        if (lo_we_i) lo_o <= data1_i;
                    end
                end

                S_RUN: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                    end else begin
                        if (is_div_q) begin
                            acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
                            acc_hi_q <= div_ge ? div_trial[WIDTH-1:0]
                                               : {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
                        end else begin
`ifndef MULDIV_FAST_MUL_EN
                            {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[WIDTH-1:1]};
`endif
                        end
                        count <= count + CW'(1);
                        if (count == CW'(WIDTH - 1)) state <= S_FIX;
                    end
                end

                S_FIX: begin
                    state <= S_IDLE;
                    // A flush landing on the FIX edge wins: no write, no done.
                    if (!flush_i) begin
                        done_o <= 1'b1;
                        if (div0_q) begin
                            hi_o <= acc_hi_q;
                            lo_o <= acc_lo_q;
                        end else if (is_div_q) begin
                            hi_o <= rem_fix;
                            lo_o <= quo_fix;
                        end else begin
                            {hi_o, lo_o} <= prod_fix;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy_o  = (state != S_IDLE);
    assign stall_o = busy_o & (start_i | hilo_rd_i | hi_we_i | lo_we_i);
    assign state_o = state;

endmodule
